ps2_scancode_rx: RTL
====================

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FILT, default 8, giving the number of consecutive identical CLK samples needed to accept a PS2_CLK level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, giving the number of CLK cycles without a PS2_CLK falling edge after which a frame in progress is aborted.
REQ-003 SHALL have port CLK, input, 1 bit: system clock.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port PS2_CLK, input, 1 bit: keyboard clock, asynchronous.
REQ-006 SHALL have port PS2_DATA, input, 1 bit: keyboard data, asynchronous.
REQ-007 SHALL have port CODE, output, 8 bits: last decoded scan code.
REQ-008 SHALL have port CODE_VALID, output, 1 bit: one-cycle strobe marking a new CODE.
REQ-009 SHALL have port BREAK, output, 1 bit: CODE is a key release (F0 prefix was seen).
REQ-010 SHALL have port EXTENDED, output, 1 bit: CODE carried the E0 prefix.
REQ-011 SHALL have port FRAME_ERR, output, 1 bit: one-cycle strobe marking a rejected frame.

Function
REQ-012 SHALL pass PS2_CLK and PS2_DATA each through a two-flop synchronizer clocked by CLK.
REQ-013 SHALL derive a filtered clock that changes level only after FILT consecutive synchronized samples at the new level; shorter pulses SHALL be ignored.
REQ-014 SHALL detect a falling edge of the filtered clock and sample synchronized PS2_DATA in that same cycle.
REQ-015 SHALL implement frame FSM states IDLE, DATA, PARITY, STOP, advancing only on a sampled falling edge.
REQ-016 In IDLE, data=0 SHALL move to DATA with bit count 0; data=1 SHALL stay in IDLE with no error.
REQ-017 In DATA, bits SHALL shift in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-018 In PARITY, the module SHALL record a parity error unless the 8 data bits plus the parity bit contain an odd number of ones; the FSM SHALL then go to STOP.
REQ-019 In STOP, a stop bit of 0 SHALL record a framing error; the FSM SHALL always return to IDLE.
REQ-020 On leaving STOP with an error, FRAME_ERR SHALL pulse for one cycle, pending prefix flags SHALL clear, and CODE_VALID SHALL stay low.
REQ-021 On leaving STOP without error, byte 0xF0 SHALL set the break_pend flag and byte 0xE0 SHALL set the ext_pend flag; neither SHALL produce CODE_VALID.
REQ-022 On leaving STOP without error, any other byte SHALL load CODE, load BREAK from break_pend and EXTENDED from ext_pend, pulse CODE_VALID, and clear both pend flags.
REQ-023 CODE_VALID or FRAME_ERR SHALL assert exactly 1 CLK cycle after the cycle in which the stop-bit falling edge is sampled.
REQ-024 CODE, BREAK and EXTENDED SHALL hold their values until the next CODE_VALID.
REQ-025 In any state other than IDLE, a counter SHALL count CLK cycles since the last falling edge.
REQ-026 When that counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, FRAME_ERR SHALL pulse, and the pend flags SHALL clear.
REQ-027 If a falling edge and the timeout occur in the same cycle, the edge SHALL win and the counter SHALL restart.
REQ-028 CODE_VALID and FRAME_ERR SHALL never assert in the same cycle.

Reset
REQ-029 RST SHALL force IDLE and clear the bit count, timeout counter and pend flags.
REQ-030 RST SHALL set CODE=0x00 and BREAK, EXTENDED, CODE_VALID, FRAME_ERR all to 0.
REQ-031 RST SHALL set the synchronizer flops and the filtered clock to 1 (line idle).
REQ-032 RST asserted mid-frame SHALL discard the partial frame with no CODE_VALID and no FRAME_ERR.

Verification
REQ-033 Bench SHALL drive frame start 0, data 0x1C, parity 0, stop 1 -> one CODE_VALID pulse, CODE=0x1C, BREAK=0, EXTENDED=0.
REQ-034 Bench SHALL drive frames F0 then 1C -> exactly one CODE_VALID, CODE=0x1C, BREAK=1, EXTENDED=0.
REQ-035 Bench SHALL drive frames E0, F0, 75 -> exactly one CODE_VALID, CODE=0x75, BREAK=1, EXTENDED=1; a following frame 1C -> BREAK=0, EXTENDED=0.
REQ-036 Bench SHALL drive 0x1C with parity 1 -> one FRAME_ERR pulse, no CODE_VALID, CODE unchanged.
REQ-037 Bench SHALL stop PS2_CLK after 5 data bits -> FRAME_ERR exactly TIMEOUT_CYC cycles after the last edge; the next good 0x1C frame -> CODE_VALID with CODE=0x1C.
REQ-038 Bench SHALL inject a PS2_CLK low glitch of FILT-1 cycles while idle -> no state change and no outputs.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver with scan-code prefix decoding
module ps2_scancode_rx #(
  parameter int FILT        = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] CODE,
  output logic       CODE_VALID,
  output logic       BREAK,
  output logic       EXTENDED,
  output logic       FRAME_ERR
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [TW-1:0] to_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          err_pend, break_pend, ext_pend;
  logic          shift_en, par_chk, stop_chk, timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips only after FILT consecutive samples disagree with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILT - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // A falling edge takes priority over an expiring timeout.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    par_chk  = 1'b0;
    stop_chk = 1'b0;
    timeout  = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_n = DATA;
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_chk = 1'b1;
          state_n = STOP;
        end
        STOP: begin
          stop_chk = 1'b1;
          state_n  = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      timeout = 1'b1;
      state_n = IDLE;
    end
  end

  // to_cnt holds the number of cycles elapsed since the last sampled edge.
  always_ff @(posedge CLK) begin
    if (RST || state_n == IDLE) to_cnt <= '0;
    else if (fall)              to_cnt <= TW'(1);
    else                        to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      err_pend   <= 1'b0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      CODE       <= 8'h00;
      BREAK      <= 1'b0;
      EXTENDED   <= 1'b0;
      CODE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      CODE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (state == IDLE && state_n == DATA) begin
        bit_cnt  <= '0;
        err_pend <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_chk) err_pend <= ~(^shreg ^ dat_s2);
      if (timeout) begin
        FRAME_ERR  <= 1'b1;
        break_pend <= 1'b0;
        ext_pend   <= 1'b0;
      end else if (stop_chk) begin
        if (err_pend || !dat_s2) begin
          FRAME_ERR  <= 1'b1;
          break_pend <= 1'b0;
          ext_pend   <= 1'b0;
        end else if (shreg == 8'hF0) begin
          break_pend <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          CODE       <= shreg;
          BREAK      <= break_pend;
          EXTENDED   <= ext_pend;
          CODE_VALID <= 1'b1;
          break_pend <= 1'b0;
          ext_pend   <= 1'b0;
        end
      end
    end
  end

endmodule
